seq_mult_ctrl: RTL and testbench
================================

# seq_mult_ctrl

Sequential shift-and-add multiplier controller for the adders/multipliers library. It accepts two WIDTH-bit unsigned operands and time-multiplexes a single WIDTH-bit ripple-carry adder over WIDTH iterations to produce a 2·WIDTH-bit product. It is the clocked, area-reduced alternative to the combinational 4×4 array multiplier and uses the same start/done handshake for every sequential arithmetic block in the library.

## Interface
- WIDTH, 4, operand width; product is 2·WIDTH bits; legal range 2..16.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only when the FSM is in IDLE or DONE.
- a  in  WIDTH  multiplicand, captured on the accepting edge.
- b  in  WIDTH  multiplier, captured on the accepting edge.
- busy  out  1  high while the FSM is in RUN; registered.
- done  out  1  one-cycle pulse when the product becomes valid; registered.
- p  out  2·WIDTH  product; holds its value until the next completion.

## Operation
- Internal registers:
  - M (WIDTH): multiplicand.
  - Acc (WIDTH): high half.
  - Q (WIDTH): low half / multiplier.
  - C (1): adder carry-out.
  - cnt: iteration counter, ceil(log2(WIDTH+1)) bits.
- FSM states:
  - IDLE
    - start=1 → RUN; load M←a, Q←b, Acc←0, C←0, cnt←0.
    - start=0 → stay in IDLE.
  - RUN (one iteration per cycle):
    - If Q[0]=1 then {C,Acc} ← Acc+M, else {C,Acc} ← {0,Acc}.
    - Then {C,Acc,Q} shifts right one bit, with C entering Acc MSB.
    - cnt ← cnt+1.
    - On the iteration with cnt=WIDTH-1: p ← shifted {Acc,Q}, then → DONE.
  - DONE
    - done=1 for this cycle only.
    - start=1 → RUN with the same load as IDLE (back-to-back operation allowed).
    - start=0 → IDLE.
- start during RUN is ignored; no queueing, and operands are not re-captured.
- a and b are don't-care except on the accepting edge.
- Arithmetic is unsigned:
  - Adder is WIDTH bits plus carry-out; the carry is never lost.
  - Result is exact, modulo nothing: max (2^W−1)² fits in 2W bits.
- Reset (rst_n=0 at an edge), including mid-RUN:
  - State → IDLE.
  - busy=0, done=0, p=0, cnt=0, Acc=Q=M=C=0.
  - Any in-flight operation is discarded without a done pulse.

## Timing
- Edge E0 accepts start. busy=1 after E0 through the cycle ending at E(WIDTH).
- The product is written at E(WIDTH). done=1 and p valid in the cycle after E(WIDTH), so latency is WIDTH+1 edges from acceptance (5 for WIDTH=4).
- busy and done are never high together.
- Back-to-back throughput: one result per WIDTH+1 cycles. busy re-asserts after the DONE-cycle edge while p still holds the previous result.
- p changes only at completion edges and at reset.
- Reset values: busy=0, done=0, p=0, state=IDLE.

## Structure
- Shared package `arith_pkg`:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding 00/01/10; 11 is illegal → IDLE.
  - Default width constant DEF_WIDTH=4.
  - Counter-width function clog2.
- Sub-module `rca_nb`: parameterised WIDTH ripple-carry adder built from full-adder cells. Ports a, b, cin, s, cout; cin is tied 0 here. It is instantiated once and holds the only combinational arithmetic. The controller holds the FSM, registers and shift.

## Test plan
- Reset, then a=0, b=0, start 1 cycle → done pulses exactly 5 cycles after acceptance, p=0x00, busy high for 4 cycles.
- a=15, b=15 → p=0xE1 (225); exercises carry-out on every iteration.
- a=13, b=11 → p=0x8F (143). Then a=1, b=0 → p=0x00, overwriting the held 0x8F only at done.
- start held high continuously with a=3, b=5, a changed to 7 mid-RUN → p=0x0F. The next operation starts from the DONE cycle with the new operands (7×5 → 0x23), with no idle gap.
- rst_n=0 for one edge during the 2nd RUN cycle of 9×9 → busy=0, p=0, no done pulse. A subsequent 2×3 gives p=0x06.
- All 256 operand pairs back-to-back, checked against a reference a·b. Assertions: done is one cycle wide, busy&done never both high, p stable between dones.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks of the adders/multipliers library.
package arith_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  // Controller states; the spare code 2'b11 is illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Ceiling log2, used to size iteration counters.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rca_nb.sv
// Parameterised ripple-carry adder built from a chain of full-adder cells.
module rca_nb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit; carry ripples from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add multiplier: one shared WIDTH-bit adder, one iteration per clock,
// start/done handshake common to the library's sequential arithmetic blocks.
module seq_mult_ctrl
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      p_q, p_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   sum;
  logic               sum_c;
  logic [WIDTH-1:0]   add_s;
  logic               add_c;

  // The only arithmetic in the block: Acc + M, carry-in unused.
  rca_nb #(
    .WIDTH (WIDTH)
  ) u_rca (
    .a    (acc_q),
    .b    (m_q),
    .cin  (1'b0),
    .s    (sum),
    .cout (sum_c)
  );

  // State, datapath and output registers; synchronous active-low reset discards any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, conditional add, right shift of {C,Acc,Q}, and next values of busy/done.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    add_s   = acc_q;
    add_c   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // Add M only when the current multiplier bit is set; carry feeds the shift.
        if (q_q[0]) begin
          add_s = sum;
          add_c = sum_c;
        end
        acc_d = {add_c, add_s[WIDTH-1:1]};
        q_d   = {add_s[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          p_d     = {acc_d, q_d};
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl (WIDTH=4) against a plain a*b reference.
module tb_seq_mult_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] p;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Continuous protocol properties sampled on the falling edge.
  logic          mon_en    = 1'b0;
  logic          done_prev = 1'b0;
  logic [PW-1:0] p_prev    = '0;
  logic          rst_edge  = 1'b0;

  always @(posedge clk) rst_edge <= !rst_n;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_and_done", 32'(busy & done), 32'd0);
      check("done_one_cycle", 32'(done & done_prev), 32'd0);
      if (!done && !rst_edge) check("p_hold", 32'(p), 32'(p_prev));
      done_prev = done;
      p_prev    = p;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drive a request at the current falling edge; returns at the falling edge after acceptance.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for done; counts edges after acceptance and cycles with busy high.
  task automatic wait_done(input bit scramble, output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic do_op(input int av, input int bv, input string tag);
    int e, bc;
    start_op(W'(av), W'(bv), 1'b0);
    wait_done(1'b1, e, bc);
    check({tag, "_latency"}, 32'(e + 1), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(W));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_p"}, 32'(p), 32'(av * bv));
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int e, bc, cur;
    int idx [256];

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    rst_n = 1'b1;
    p_prev = p;
    done_prev = 1'b0;
    mon_en = 1'b1;

    do_op(0, 0, "zero_zero");
    idle_cycle();
    do_op(15, 15, "max_max");
    idle_cycle();
    do_op(13, 11, "d_b");
    idle_cycle();
    check("hold_8f_idle", 32'(p), 32'h8F);
    start_op(W'(1), W'(0), 1'b0);
    check("hold_8f_run", 32'(p), 32'h8F);
    wait_done(1'b1, e, bc);
    check("one_zero_p", 32'(p), 32'h00);
    idle_cycle();

    // start held high; operand change during RUN must not be re-captured.
    start_op(W'(3), W'(5), 1'b1);
    a = W'(7);
    wait_done(1'b0, e, bc);
    check("b2b_first_p", 32'(p), 32'h0F);
    check("b2b_first_lat", 32'(e + 1), 32'(W + 1));
    idle_cycle();
    check("b2b_rerun_busy", 32'(busy), 32'd1);
    check("b2b_rerun_p_held", 32'(p), 32'h0F);
    wait_done(1'b0, e, bc);
    check("b2b_second_p", 32'(p), 32'h23);
    check("b2b_second_lat", 32'(e + 1), 32'(W + 1));
    start = 1'b0;
    idle_cycle();

    // Reset during the 2nd RUN cycle of 9x9.
    start_op(W'(9), W'(9), 1'b0);
    idle_cycle();
    rst_n = 1'b0;
    idle_cycle();
    rst_n = 1'b1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_p", 32'(p), 32'd0);
    repeat (8) begin
      idle_cycle();
      check("no_done_after_rst", 32'(done), 32'd0);
      check("no_busy_after_rst", 32'(busy), 32'd0);
    end
    do_op(2, 3, "two_three");
    idle_cycle();

    // All operand pairs, shuffled, fully back-to-back.
    for (int i = 0; i < 256; i++) idx[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = idx[i];
      idx[i] = idx[j];
      idx[j] = t;
    end
    cur = idx[0];
    start_op(W'(cur >> 4), W'(cur & 15), 1'b1);
    for (int k = 0; k < 256; k++) begin
      wait_done(1'b1, e, bc);
      check("all_pairs_p", 32'(p), 32'((cur >> 4) * (cur & 15)));
      check("all_pairs_lat", 32'(e + 1), 32'(W + 1));
      if (k < 255) begin
        cur = idx[k + 1];
        a = W'(cur >> 4);
        b = W'(cur & 15);
        idle_cycle();
      end else begin
        start = 1'b0;
      end
    end
    idle_cycle();

    // Random operations with random idle gaps (gap 0 restarts from DONE).
    for (int k = 0; k < 20; k++) begin
      int av, bv, gap;
      av  = int'($urandom_range(15, 0));
      bv  = int'($urandom_range(15, 0));
      gap = int'($urandom_range(3, 0));
      do_op(av, bv, "rand_op");
      for (int g = 0; g < gap; g++) idle_cycle();
    end
    start = 1'b0;
    repeat (3) idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
